alarm_timer: RTL and testbench
==============================

# alarm_timer

Countdown timer that sits directly upstream of the buzzer stage. It counts down a preset number of seconds on the 1 kHz `clkms` clock. On expiry it raises the buzzer enable, holds it until the buzzer reports completion, then drops it so the buzzer re-arms. It replaces ad-hoc enable generation in Core with a single start/stop/done interface.

## Interface
- `MS_PER_SEC`, default 1000: `clkms` cycles per second tick. Benches may override it to a small value.
- `SEC_W`, default 12: width of the seconds count. Max preset is 4095 s.

- `clkms`  in  1  1 kHz system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  1-cycle pulse. Loads and runs from IDLE, or resumes from PAUSED.
- `stop`  in  1  1-cycle pulse. Pauses, clears or aborts, depending on state.
- `load_sec`  in  SEC_W  preset seconds, sampled on `start` in IDLE only.
- `buzz_finished`  in  1  completion flag from the buzzer. Stays high while `buzz_enable` is high.
- `buzz_enable`  out  1  enable to the buzzer.
- `remaining_sec`  out  SEC_W  whole seconds left.
- `running`  out  1  high in RUN.
- `done`  out  1  1-cycle pulse when an alarm completes normally.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: counting down.
  - PAUSED: count frozen.
  - ALARM: `buzz_enable` high.
- IDLE:
  - `start` with `load_sec` != 0 → RUN. `remaining_sec` <= `load_sec`; ms count <= 0.
  - `start` with `load_sec` == 0 is ignored.
- RUN:
  - Ms count increments each cycle.
  - At `MS_PER_SEC`-1 it wraps to 0 and `remaining_sec` decrements.
  - When the decrement takes `remaining_sec` from 1 to 0 → ALARM, with `buzz_enable` <= 1.
  - `stop` → PAUSED. Ms count and `remaining_sec` are held with no tick that cycle.
- PAUSED:
  - `start` → RUN, continuing from the held ms count.
  - `stop` → IDLE, clearing `remaining_sec` and the ms count.
- ALARM:
  - `buzz_finished` = 1 → IDLE. `buzz_enable` <= 0 and `done` pulses for 1 cycle.
  - `stop` → IDLE with `buzz_enable` <= 0 and no `done` (abort).
- `start` and `stop` in the same cycle: `stop` wins.
- `start` in RUN or ALARM is ignored. `stop` in IDLE is ignored.
- `buzz_finished` outside ALARM is ignored.
- `buzz_enable` is always low for at least one cycle between alarms. The buzzer needs this low cycle to clear its state.

## Timing
- Reset values: `buzz_enable`=0, `remaining_sec`=0, `running`=0, `done`=0. State is IDLE and ms count is 0.
- Reset has priority over all inputs and aborts any state in one edge.
- All outputs are registered. No combinational path from input to output.
- Latency: with `start` sampled at edge 0 and `load_sec`=N, `buzz_enable` is first high after edge N·`MS_PER_SEC`.
  - At that same edge `remaining_sec` becomes 0 and `running` falls.
- A pause of P cycles delays alarm entry by exactly P cycles.
- `buzz_finished` sampled high at edge k gives `buzz_enable`=0 and `done`=1 after edge k. `done`=0 again after edge k+1.
- Ms count width is clog2(`MS_PER_SEC`). `remaining_sec` never underflows; the decrement only happens when it is non-zero.

## Structure
- Shared package `timer_pkg`:
  - state enum (IDLE, RUN, PAUSED, ALARM)
  - default `MS_PER_SEC` and `SEC_W` constants
- Sub-module `ms_prescaler`:
  - Inputs: `clkms`, `reset`, `clear`, `en`.
  - Output: `tick`, a 1-cycle pulse when the count wraps.
  - Counts 0..`MS_PER_SEC`-1.
- Top level holds the FSM and the seconds counter.

## Test plan
All scenarios use `MS_PER_SEC`=4.
1. Basic countdown:
   - `load_sec`=3 and `start` at edge 0 → `remaining_sec` 3,2,1 at 4-cycle steps; `buzz_enable`=1 after edge 12.
   - `buzz_finished`=1 at edge 20 → `buzz_enable`=0 and `done`=1 after edge 20.
2. Pause and resume:
   - `load_sec`=2; `stop` at edge 5; `start` at edge 10 → `buzz_enable` rises after edge 13.
3. Abort:
   - `stop` while in ALARM → `buzz_enable`=0 next cycle, `done` never pulses, state IDLE.
   - `stop` twice from RUN → `remaining_sec`=0.
4. Edge inputs:
   - `start` with `load_sec`=0 → no state change.
   - `start`+`stop` together in IDLE → stays IDLE.
   - `start`+`stop` together in PAUSED → IDLE.
   - `start` pulses during RUN → no effect on timing.
5. Reset mid-operation:
   - `reset` in RUN → all outputs 0 next cycle.
   - `reset` in ALARM → `buzz_enable` 0 next cycle.
   - A new `start` afterwards counts from the new `load_sec`.
6. Back-to-back alarms:
   - `start` on the cycle after `done` → `buzz_enable` has been low ≥1 cycle between alarms.
   - `buzz_finished` held high leftover from the buzzer is ignored until ALARM.

Source files
------------

// File: rtl/alarm_timer_pkg.sv
// Shared types and defaults for the alarm timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

    // Default clkms cycles per one-second tick and seconds-counter width.
    localparam int DEF_MS_PER_SEC = 1000;
    localparam int DEF_SEC_W      = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_ALARM  = 2'd3
    } state_e;

endpackage

// File: rtl/alarm_timer_if.sv
// Control/status bundle between Core (master) and the alarm timer (slave).
// Latency: n/a (wiring only).
// Backpressure: none; start/stop are single-cycle pulses, buzz_finished is a level.
//   start, stop     : command pulses from Core
//   load_sec        : preset seconds, sampled on start in IDLE
//   buzz_finished   : completion level from the buzzer
//   buzz_enable, remaining_sec, running, done : registered timer status
interface alarm_timer_if
    import timer_pkg::*;
#(
    parameter int SEC_W = DEF_SEC_W
);
    logic             start;
    logic             stop;
    logic [SEC_W-1:0] load_sec;
    logic             buzz_finished;
    logic             buzz_enable;
    logic [SEC_W-1:0] remaining_sec;
    logic             running;
    logic             done;

    modport master (
        output start, stop, load_sec, buzz_finished,
        input  buzz_enable, remaining_sec, running, done
    );

    modport slave (
        input  start, stop, load_sec, buzz_finished,
        output buzz_enable, remaining_sec, running, done
    );
endinterface

// File: rtl/alarm_timer_ms_prescaler.sv
// Millisecond prescaler: counts 0..MS_PER_SEC-1 while enabled and flags the wrap.
// Latency: tick is combinational from the held count, asserted in the cycle whose edge wraps it.
// Backpressure: none; en freezes the count, clear zeroes it (clear wins over en).
//   clkms, reset : clock and synchronous active-high reset
//   clear, en    : zero the count / advance the count
//   tick         : high when an enabled count sits at MS_PER_SEC-1
module ms_prescaler
    import timer_pkg::*;
#(
    parameter int MS_PER_SEC = DEF_MS_PER_SEC
) (
    input  logic clkms,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);
    // Keep at least one bit so MS_PER_SEC=1 still elaborates.
    localparam int CNT_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && !clear && (cnt == LAST);

    always_ff @(posedge clkms) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/alarm_timer.sv
// Countdown alarm timer driving the buzzer enable; FSM plus seconds counter.
// Latency: buzz_enable rises at edge N*MS_PER_SEC after the start edge (plus any paused cycles).
// Backpressure: none; buzz_enable is held until buzz_finished or stop, then drops for >=1 cycle.
//   clkms, reset : 1 kHz clock, synchronous active-high reset
//   tif (slave)  : start/stop/load_sec/buzz_finished in; buzz_enable/remaining_sec/running/done out
module alarm_timer
    import timer_pkg::*;
#(
    parameter int MS_PER_SEC = DEF_MS_PER_SEC,
    parameter int SEC_W      = DEF_SEC_W
) (
    input  logic         clkms,
    input  logic         reset,
    alarm_timer_if.slave tif
);
    localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
    localparam logic [1:0] S_RUN    = 2'(ST_RUN);
    localparam logic [1:0] S_PAUSED = 2'(ST_PAUSED);
    localparam logic [1:0] S_ALARM  = 2'(ST_ALARM);

    logic [1:0]       state;
    logic [SEC_W-1:0] rem;
    logic             buzz_en_q;
    logic             running_q;
    logic             done_q;
    logic             pre_en;
    logic             pre_clr;
    logic             tick;

    // The prescaler advances in RUN and also on the resume edge out of PAUSED,
    // so a pause of P cycles shifts the alarm by exactly P cycles. stop always
    // freezes it for the cycle it is seen.
    always_comb begin
        pre_en  = 1'b0;
        pre_clr = 1'b0;
        if (!tif.stop) begin
            pre_en = (state == S_RUN) || ((state == S_PAUSED) && tif.start);
        end
        pre_clr = (state == S_IDLE) || ((state == S_PAUSED) && tif.stop);
    end

    ms_prescaler #(
        .MS_PER_SEC (MS_PER_SEC)
    ) u_prescaler (
        .clkms (clkms),
        .reset (reset),
        .clear (pre_clr),
        .en    (pre_en),
        .tick  (tick)
    );

    always_ff @(posedge clkms) begin
        if (reset) begin
            state     <= S_IDLE;
            rem       <= '0;
            buzz_en_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tif.start && !tif.stop && (tif.load_sec != '0)) begin
                        state     <= S_RUN;
                        rem       <= tif.load_sec;
                        running_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (tif.stop) begin
                        state     <= S_PAUSED;
                        running_q <= 1'b0;
                    end
                end
                S_PAUSED: begin
                    if (tif.stop) begin
                        state <= S_IDLE;
                        rem   <= '0;
                    end else if (tif.start) begin
                        state     <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                S_ALARM: begin
                    // Abort takes precedence over a simultaneous completion.
                    if (tif.stop) begin
                        state     <= S_IDLE;
                        buzz_en_q <= 1'b0;
                    end else if (tif.buzz_finished) begin
                        state     <= S_IDLE;
                        buzz_en_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Second tick; only possible in RUN or on the resume edge, and
            // overrides the plain RUN transition above when the count expires.
            if (tick && (rem != '0)) begin
                rem <= rem - 1'b1;
                if (rem == SEC_W'(1)) begin
                    state     <= S_ALARM;
                    buzz_en_q <= 1'b1;
                    running_q <= 1'b0;
                end
            end
        end
    end

    assign tif.buzz_enable   = buzz_en_q;
    assign tif.remaining_sec = rem;
    assign tif.running       = running_q;
    assign tif.done          = done_q;
endmodule

// File: tb/tb_alarm_timer.sv
module tb_alarm_timer;
    localparam int M  = 4;
    localparam int SW = 12;

    logic clkms = 1'b0;
    logic reset;
    always #5 clkms = ~clkms;

    alarm_timer_if #(.SEC_W(SW)) tif();

    alarm_timer #(
        .MS_PER_SEC (M),
        .SEC_W      (SW)
    ) dut (
        .clkms (clkms),
        .reset (reset),
        .tif   (tif)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 idle, 1 run, 2 paused, 3 alarm.
    // Time is tracked as total elapsed run-milliseconds; seconds left are
    // derived arithmetically from it.
    int   m_mode = 0;
    int   m_n    = 0;
    int   m_el   = 0;
    logic m_done = 1'b0;

    function automatic logic [SW+2:0] exp_vec();
        int r;
        r = (m_mode == 0) ? 0 : (m_n - m_el / M);
        return {(m_mode == 3), (m_mode == 1), m_done, SW'(r)};
    endfunction

    function automatic logic [SW+2:0] obs_vec();
        return {tif.buzz_enable, tif.running, tif.done, tif.remaining_sec};
    endfunction

    // One clock: drive inputs, take the edge, advance the model, settle.
    task automatic cyc(input logic st, input logic sp, input logic bf,
                       input logic rs, input logic [SW-1:0] ld);
        tif.start         = st;
        tif.stop          = sp;
        tif.buzz_finished = bf;
        tif.load_sec      = ld;
        reset             = rs;
        @(posedge clkms);
        m_done = 1'b0;
        if (rs) begin
            m_mode = 0; m_n = 0; m_el = 0;
        end else begin
            case (m_mode)
                0: if (st && !sp && ld != 0) begin
                       m_mode = 1; m_n = int'(ld); m_el = 0;
                   end
                1: if (sp) m_mode = 2;
                   else begin
                       m_el++;
                       if (m_el == m_n * M) m_mode = 3;
                   end
                2: if (sp) begin
                       m_mode = 0; m_n = 0; m_el = 0;
                   end else if (st) begin
                       m_mode = 1; m_el++;
                       if (m_el == m_n * M) m_mode = 3;
                   end
                3: if (sp) m_mode = 0;
                   else if (bf) begin
                       m_mode = 0; m_done = 1'b1;
                   end
                default: m_mode = 0;
            endcase
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0);
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 1, '0);
        cyc(0, 0, 0, 1, '0);
        n_checks++;
        if (obs_vec() !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got %h want 0", obs_vec());
        end
        cyc(0, 0, 0, 0, '0);
    endtask

    task automatic test_basic();
        cyc(1, 0, 0, 0, SW'(3));              // edge 0
        n_checks++;
        if (tif.remaining_sec !== SW'(3) || tif.running !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_load rem %0d run %b want 3 1", tif.remaining_sec, tif.running);
        end
        for (int e = 1; e <= 12; e++) begin
            cyc(0, 0, 0, 0, '0);
            if (e == 4 || e == 8) begin
                n_checks++;
                if (tif.remaining_sec !== SW'(3 - e / 4)) begin
                    n_errors++;
                    $display("FAIL basic_rem e%0d got %0d want %0d", e, tif.remaining_sec, 3 - e / 4);
                end
            end
            if (e == 11) begin
                n_checks++;
                if (tif.buzz_enable !== 1'b0) begin
                    n_errors++;
                    $display("FAIL basic_early_buzz got %b want 0", tif.buzz_enable);
                end
            end
        end
        n_checks++;
        if (obs_vec() !== {1'b1, 1'b0, 1'b0, SW'(0)}) begin
            n_errors++;
            $display("FAIL basic_alarm got %h want %h", obs_vec(), {1'b1, 1'b0, 1'b0, SW'(0)});
        end
        idle(7);                               // edges 13..19
        cyc(0, 0, 1, 0, '0);                   // edge 20
        n_checks++;
        if (tif.buzz_enable !== 1'b0 || tif.done !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_done be %b done %b want 0 1", tif.buzz_enable, tif.done);
        end
        cyc(0, 0, 0, 0, '0);                   // edge 21
        n_checks++;
        if (tif.done !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_done_pulse got %b want 0", tif.done);
        end
    endtask

    task automatic test_pause();
        cyc(1, 0, 0, 0, SW'(2));              // edge 0
        idle(4);                               // edges 1..4
        cyc(0, 1, 0, 0, '0);                   // edge 5
        n_checks++;
        if (tif.running !== 1'b0 || tif.remaining_sec !== SW'(1)) begin
            n_errors++;
            $display("FAIL pause_hold run %b rem %0d want 0 1", tif.running, tif.remaining_sec);
        end
        idle(4);                               // edges 6..9
        cyc(1, 0, 0, 0, '0);                   // edge 10
        idle(2);                               // edges 11,12
        n_checks++;
        if (tif.buzz_enable !== 1'b0) begin
            n_errors++;
            $display("FAIL pause_early_buzz got %b want 0", tif.buzz_enable);
        end
        idle(1);                               // edge 13
        n_checks++;
        if (tif.buzz_enable !== 1'b1) begin
            n_errors++;
            $display("FAIL pause_buzz got %b want 1", tif.buzz_enable);
        end
        cyc(0, 0, 1, 0, '0);
        idle(1);
    endtask

    task automatic test_abort();
        cyc(1, 0, 0, 0, SW'(1));
        idle(4);
        cyc(0, 1, 0, 0, '0);                   // stop in ALARM
        n_checks++;
        if (tif.buzz_enable !== 1'b0 || tif.done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_alarm be %b done %b want 0 0", tif.buzz_enable, tif.done);
        end
        idle(1);
        n_checks++;
        if (obs_vec() !== '0) begin
            n_errors++;
            $display("FAIL abort_idle got %h want 0", obs_vec());
        end
        cyc(1, 0, 0, 0, SW'(3));
        idle(2);
        cyc(0, 1, 0, 0, '0);
        cyc(0, 1, 0, 0, '0);
        n_checks++;
        if (tif.remaining_sec !== SW'(0) || tif.running !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_stop2 rem %0d run %b want 0 0", tif.remaining_sec, tif.running);
        end
    endtask

    task automatic test_edge_inputs();
        cyc(1, 0, 0, 0, SW'(0));
        n_checks++;
        if (tif.running !== 1'b0) begin
            n_errors++;
            $display("FAIL edge_load0 run %b want 0", tif.running);
        end
        cyc(1, 1, 0, 0, SW'(2));
        n_checks++;
        if (tif.running !== 1'b0 || tif.remaining_sec !== SW'(0)) begin
            n_errors++;
            $display("FAIL edge_both_idle run %b rem %0d want 0 0", tif.running, tif.remaining_sec);
        end
        cyc(1, 0, 0, 0, SW'(2));
        idle(1);
        cyc(0, 1, 0, 0, '0);
        cyc(1, 1, 0, 0, '0);
        idle(1);
        n_checks++;
        if (tif.running !== 1'b0 || tif.remaining_sec !== SW'(0)) begin
            n_errors++;
            $display("FAIL edge_both_paused run %b rem %0d want 0 0", tif.running, tif.remaining_sec);
        end
        cyc(1, 0, 0, 0, SW'(2));               // edge 0
        for (int e = 1; e <= 7; e++) cyc(e % 2 == 1, 0, 0, 0, SW'(3));
        n_checks++;
        if (tif.buzz_enable !== 1'b0 || tif.remaining_sec !== SW'(1)) begin
            n_errors++;
            $display("FAIL edge_start_run be %b rem %0d want 0 1", tif.buzz_enable, tif.remaining_sec);
        end
        cyc(1, 0, 0, 0, SW'(3));               // edge 8
        n_checks++;
        if (tif.buzz_enable !== 1'b1) begin
            n_errors++;
            $display("FAIL edge_start_run_alarm got %b want 1", tif.buzz_enable);
        end
        cyc(0, 0, 1, 0, '0);
        idle(1);
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 0, 0, SW'(3));
        idle(5);
        cyc(0, 0, 0, 1, '0);
        n_checks++;
        if (obs_vec() !== '0) begin
            n_errors++;
            $display("FAIL rst_run got %h want 0", obs_vec());
        end
        cyc(1, 0, 0, 0, SW'(1));
        idle(4);
        cyc(0, 0, 0, 1, '0);
        n_checks++;
        if (tif.buzz_enable !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_alarm be %b want 0", tif.buzz_enable);
        end
        cyc(1, 0, 0, 0, SW'(2));
        idle(7);
        n_checks++;
        if (tif.buzz_enable !== 1'b0 || tif.remaining_sec !== SW'(1)) begin
            n_errors++;
            $display("FAIL rst_restart be %b rem %0d want 0 1", tif.buzz_enable, tif.remaining_sec);
        end
        idle(1);
        n_checks++;
        if (tif.buzz_enable !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_restart_alarm got %b want 1", tif.buzz_enable);
        end
        cyc(0, 0, 1, 0, '0);
        idle(1);
    endtask

    task automatic test_back_to_back();
        int low_cycles;
        cyc(1, 0, 0, 0, SW'(1));
        idle(4);
        cyc(0, 0, 1, 0, '0);                   // done
        low_cycles = (tif.buzz_enable === 1'b0) ? 1 : 0;
        cyc(1, 0, 1, 0, SW'(1));               // restart with leftover finished
        if (tif.buzz_enable === 1'b0) low_cycles++;
        cyc(0, 0, 1, 0, '0);
        if (tif.buzz_enable === 1'b0) low_cycles++;
        n_checks++;
        if (low_cycles < 2 || tif.running !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_gap low %0d run %b want >=2 1", low_cycles, tif.running);
        end
        idle(3);
        n_checks++;
        if (tif.buzz_enable !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_second_alarm got %b want 1", tif.buzz_enable);
        end
        idle(1);
        n_checks++;
        if (tif.buzz_enable !== 1'b1 || tif.done !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_hold be %b done %b want 1 0", tif.buzz_enable, tif.done);
        end
        cyc(0, 0, 1, 0, '0);
        n_checks++;
        if (tif.done !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_done got %b want 1", tif.done);
        end
        idle(1);
    endtask

    task automatic test_random();
        logic st, sp, bf, rs;
        logic [SW-1:0] ld;
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 14) == 0);
            bf = (m_mode == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            rs = ($urandom_range(0, 399) == 0);
            ld = SW'($urandom_range(0, 3));
            cyc(st, sp, bf, rs, ld);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL random_c%0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        tif.start         = 1'b0;
        tif.stop          = 1'b0;
        tif.buzz_finished = 1'b0;
        tif.load_sec      = '0;
        reset             = 1'b1;
        test_reset();
        test_basic();
        test_pause();
        test_abort();
        test_edge_inputs();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
